xor3_parity_arbiter: RTL
========================

// Module: xor3_parity_arbiter
// PURPOSE
//  Shares one gf180mcu_fd_sc_mcu9t5v0__xor3_1 cell, instantiated inside this block, among NREQ requesters.
//  - Each requester submits a WIDTH-bit word and receives its even-parity bit (XOR of all bits).
//  - Words are serialised 2 bits/cycle: A1/A2 carry data bits, A3 carries the running accumulator.
//  - Round-robin arbitration; one word in flight at a time.
// PARAMETERS
//  NREQ   4   number of requesters (>=2)
//  WIDTH  16  data word width (even, >=2)
//  IDW    $clog2(NREQ)  requester-id width (derived; not to be overridden)
// PORTS
//  CLK         input   1           rising-edge clock
//  RST         input   1           synchronous reset, active-high
//  REQ_VALID   input   NREQ        per-requester word valid
//  REQ_DATA    input   NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
//  REQ_READY   output  NREQ        per-requester accept; transfer = VALID & READY
//  RSP_VALID   output  1           parity result valid
//  RSP_ID      output  IDW         requester index owning the result
//  RSP_PARITY  output  1           XOR-reduction of the accepted word
//  RSP_READY   input   1           result consumer ready
//  BUSY        output  1           high whenever state != IDLE
//  VDD         inout   1           supply; passed to xor3 instance, no logic
//  VSS         inout   1           ground; passed to xor3 instance, no logic
// BEHAVIOUR
//  Reset
//  - Sync on RST=1 at a CLK edge: state=IDLE, ptr=0, acc=0, cnt=0.
//  - RSP_VALID/RSP_ID/RSP_PARITY=0; REQ_READY=0; BUSY=0.
//  - RST overrides every other input in the same cycle.
//  State machine
//  - IDLE: grant = first i with REQ_VALID[i]=1, searching ptr, ptr+1, ... mod NREQ.
//    - REQ_READY[grant]=1, combinational from REQ_VALID and state; all other bits 0.
//    - REQ_READY is all-zero outside IDLE and when no request is valid.
//    - On a transfer: sh<=REQ_DATA[grant], id<=grant, acc<=0, cnt<=WIDTH/2-1, go RUN.
//  - RUN: xor3 A1=sh[0], A2=sh[1], A3=acc.
//    - acc<=Z; sh<=sh>>2; cnt<=cnt-1.
//    - When cnt==0, the update still applies and the state goes to DONE.
//  - DONE: RSP_VALID=1, RSP_PARITY=acc, RSP_ID=id; all three are registered.
//    - They are held stable until RSP_READY=1.
//    - On RSP_READY=1: ptr<=(id+1) mod NREQ, RSP_VALID<=0, go IDLE.
//  Timing
//  - Latency: accept edge at cycle 0 -> RSP_VALID high at cycle WIDTH/2+1.
//  - Min spacing between accepts is WIDTH/2+2 cycles; no accept in the cycle DONE completes.
//  Rules and boundary conditions
//  - Requester holds VALID/DATA stable until accepted.
//  - Dropping VALID before accept is legal and ignored; no request is latched.
//  - Simultaneous valids: exactly one is granted; the others wait with READY=0.
//  - Wrap: ptr NREQ-1 -> 0.
//  - Only the granted requester's word is sampled; later changes to REQ_DATA do not affect the result.
//  - RSP_READY while RSP_VALID=0 is ignored.
//  - RST in RUN or DONE: the in-flight word is discarded, no response is issued, and ptr returns to 0.
//  - RSP_PARITY must equal ^word for every value, including all-0 and all-1 words.
// TESTING  (NREQ=4, WIDTH=16)
//  1 Reset: RST=1 for 2 cycles with all REQ_VALID=1 -> REQ_READY=0, RSP_VALID=0, BUSY=0 throughout.
//  2 Single: req0 data 16'h0001, RSP_READY=1 -> REQ_READY[0] at cycle 0; RSP_VALID at cycle 9 with PARITY=1, ID=0.
//  3 Data corners on req1: 16'hFFFF -> PARITY=0; 16'h0000 -> 0; 16'hA5A4 -> 1; 16'h8000 -> 1.
//  4 Fairness: all 4 valid continuously, RSP_READY=1 -> grant order 0,1,2,3,0; accepts spaced 10 cycles apart.
//  5 Backpressure: RSP_READY=0 for 5 cycles during DONE -> RSP_VALID/ID/PARITY stable, REQ_READY=0, BUSY=1.
//  6 Reset mid-RUN (cycle 4), req2 and req3 valid after -> no response for the old word; req2 granted first, then req3.

Source files
------------

// File: rtl/xor3_parity_arbiter_if.sv
// -----------------------------------------------------------------------------
// xor3_parity_arbiter_if
// Request/response bundle between NREQ requesters and the shared-XOR3 parity
// engine.
//   REQ_VALID  [NREQ]        per-requester word valid        (master -> slave)
//   REQ_DATA   [NREQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   REQ_READY  [NREQ]        per-requester accept            (slave -> master)
//   RSP_VALID                parity result valid             (slave -> master)
//   RSP_ID     [IDW]         requester owning the result     (slave -> master)
//   RSP_PARITY               XOR-reduction of accepted word  (slave -> master)
//   RSP_READY                result consumer ready           (master -> slave)
//   BUSY                     engine not idle                 (slave -> master)
// -----------------------------------------------------------------------------
interface xor3_parity_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       REQ_VALID;
  logic [NREQ*WIDTH-1:0] REQ_DATA;
  logic [NREQ-1:0]       REQ_READY;
  logic                  RSP_VALID;
  logic [IDW-1:0]        RSP_ID;
  logic                  RSP_PARITY;
  logic                  RSP_READY;
  logic                  BUSY;

  modport master (
    output REQ_VALID, REQ_DATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_ID, RSP_PARITY, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_ID, RSP_PARITY, BUSY
  );
endinterface

// File: rtl/xor3_parity_arbiter.sv
// -----------------------------------------------------------------------------
// xor3_parity_arbiter
// Shares a single 3-input XOR standard cell among NREQ requesters. A granted
// word is shifted through the cell two bits per cycle (A1/A2 = data bits,
// A3 = running accumulator); the final accumulator is the even-parity bit.
// Round-robin arbitration, one word in flight at a time.
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous reset, active-high
//   bus   xor3_parity_arbiter_if.slave (request/response handshakes, BUSY)
//   VDD   supply, passed to the XOR3 cell only
//   VSS   ground, passed to the XOR3 cell only
// -----------------------------------------------------------------------------

// Behavioural stand-in for the gf180mcu 3-input XOR cell; supply pins carry no
// logic.
module gf180mcu_fd_sc_mcu9t5v0__xor3_1 (
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic Z,
  inout  wire  VDD,
  inout  wire  VSS
);
  assign Z = A1 ^ A2 ^ A3;
endmodule

module xor3_parity_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 16,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  xor3_parity_arbiter_if.slave   bus,
  inout  wire                    VDD,
  inout  wire                    VSS
);

  localparam int HALF = WIDTH / 2;
  localparam int CNTW = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [WIDTH-1:0]  r_sh;
  logic              r_acc;
  logic [CNTW-1:0]   r_cnt;
  logic              r_rsp_valid;
  logic              r_rsp_parity;
  logic [IDW-1:0]    r_rsp_id;

  logic [IDW-1:0]    w_grant;
  logic              w_found;
  logic [NREQ-1:0]   w_ready;
  logic              w_xfer;
  logic              w_z;

  // Round-robin search starting at r_ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] cand;
    w_grant = '0;
    w_found = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx  = (32'(r_ptr) + k) % NREQ;
      cand = IDW'(idx);
      if (!w_found && bus.REQ_VALID[cand]) begin
        w_found = 1'b1;
        w_grant = cand;
      end
    end
  end

  // Next-state and REQ_READY. RST gates READY so nothing is accepted in a
  // reset cycle.
  always_comb begin
    w_next  = r_state;
    w_ready = '0;
    unique case (r_state)
      S_IDLE: begin
        if (!RST && w_found) begin
          w_ready[w_grant] = 1'b1;
          w_next           = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.RSP_READY) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_xfer = (r_state == S_IDLE) && w_found && !RST;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_sh         <= '0;
      r_acc        <= 1'b0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_parity <= 1'b0;
      r_rsp_id     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_sh  <= bus.REQ_DATA[w_grant*WIDTH +: WIDTH];
            r_id  <= w_grant;
            r_acc <= 1'b0;
            r_cnt <= CNTW'(HALF - 1);
          end
        end
        S_RUN: begin
          r_acc <= w_z;
          r_sh  <= r_sh >> 2;
          r_cnt <= r_cnt - 1'b1;
          // Last pair: the response registers take the final accumulator
          // directly so they are valid on entry to DONE.
          if (r_cnt == '0) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_parity <= w_z;
            r_rsp_id     <= r_id;
          end
        end
        S_DONE: begin
          if (bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  gf180mcu_fd_sc_mcu9t5v0__xor3_1 u_xor3 (
    .A1  (r_sh[0]),
    .A2  (r_sh[1]),
    .A3  (r_acc),
    .Z   (w_z),
    .VDD (VDD),
    .VSS (VSS)
  );

  assign bus.REQ_READY  = w_ready;
  assign bus.RSP_VALID  = r_rsp_valid;
  assign bus.RSP_ID     = r_rsp_id;
  assign bus.RSP_PARITY = r_rsp_parity;
  assign bus.BUSY       = (r_state != S_IDLE);

endmodule
